// File: rtl/crc_sched.sv
// Round-robin scheduler sharing one bit-serial CRC-8 engine among N_REQ byte requesters.
// Streams the winner's byte LSB-first into the engine and returns the collected serial CRC.
module crc_sched #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   Req,
    input  logic [8*N_REQ-1:0] Req_Data,
    output logic [N_REQ-1:0]   Grant,
    output logic [N_REQ-1:0]   Done,
    output logic [N_REQ-1:0]   Err,
    output logic [7:0]         Crc_Out,
    output logic               Busy,
    output logic               Eng_RST,
    output logic               Eng_Data,
    output logic               Eng_Active,
    input  logic               Eng_CRC,
    input  logic               Eng_Valid
);
    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = ($clog2(TIMEOUT) > 3) ? $clog2(TIMEOUT) : 3;

    typedef enum logic [2:0] {
        StIdle, StClear, StRecover, StShift, StWaitV, StCollect, StDone
    } state_e;

    state_e           r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_win;
    logic [7:0]       r_byte;
    logic [7:0]       r_shadow;
    logic [7:0]       r_crc;
    logic [CW-1:0]    r_cnt;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] r_done;
    logic [N_REQ-1:0] r_err;
    logic             r_busy;
    logic             r_eng_rst;
    logic             r_eng_data;
    logic             r_eng_active;

    logic             w_any;
    logic [IW-1:0]    w_win;
    logic [7:0]       w_byte;
    int unsigned      w_idx;
    logic [N_REQ-1:0] w_grant_oh;
    logic [N_REQ-1:0] w_win_oh;

    // First asserted request at or above the pointer, wrapping around.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_byte = '0;
        w_idx  = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = (32'(r_ptr) + k) % N_REQ;
            if (!w_any && Req[w_idx]) begin
                w_any  = 1'b1;
                w_win  = IW'(w_idx);
                w_byte = Req_Data[8*w_idx +: 8];
            end
        end
    end

    assign w_grant_oh = N_REQ'(1) << w_win;
    assign w_win_oh   = N_REQ'(1) << r_win;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= StIdle;
            r_ptr        <= '0;
            r_win        <= '0;
            r_byte       <= '0;
            r_shadow     <= '0;
            r_crc        <= '0;
            r_cnt        <= '0;
            r_grant      <= '0;
            r_done       <= '0;
            r_err        <= '0;
            r_busy       <= 1'b0;
            r_eng_rst    <= 1'b1;
            r_eng_data   <= 1'b0;
            r_eng_active <= 1'b0;
        end else begin
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_state   <= StClear;
                        r_win     <= w_win;
                        r_byte    <= w_byte;
                        r_ptr     <= (32'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
                        r_grant   <= w_grant_oh;
                        r_eng_rst <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                StClear: begin
                    r_state   <= StRecover;
                    r_eng_rst <= 1'b1;
                end
                StRecover: begin
                    r_state      <= StShift;
                    r_eng_active <= 1'b1;
                    r_eng_data   <= r_byte[0];
                    r_byte       <= r_byte >> 1;
                    r_cnt        <= '0;
                end
                StShift: begin
                    if (r_cnt == CW'(7)) begin
                        r_state      <= StWaitV;
                        r_eng_active <= 1'b0;
                        r_eng_data   <= 1'b0;
                        r_cnt        <= '0;
                    end else begin
                        r_eng_data <= r_byte[0];
                        r_byte     <= r_byte >> 1;
                        r_cnt      <= r_cnt + 1'b1;
                    end
                end
                StWaitV: begin
                    if (Eng_Valid) begin
                        r_shadow <= {Eng_CRC, r_shadow[7:1]};
                        r_cnt    <= '0;
                        r_state  <= StCollect;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err   <= w_win_oh;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StCollect: begin
                    if (!Eng_Valid) begin
                        r_err   <= w_win_oh;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else if (r_cnt == CW'(6)) begin
                        // Shadow fills from the top, so the first bit lands in bit 0.
                        r_crc   <= {Eng_CRC, r_shadow[7:1]};
                        r_done  <= w_win_oh;
                        r_state <= StDone;
                    end else begin
                        r_shadow <= {Eng_CRC, r_shadow[7:1]};
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign Grant      = r_grant;
    assign Done       = r_done;
    assign Err        = r_err;
    assign Crc_Out    = r_crc;
    assign Busy       = r_busy;
    assign Eng_RST    = r_eng_rst;
    assign Eng_Data   = r_eng_data;
    assign Eng_Active = r_eng_active;

endmodule

// File: tb/tb_crc_sched.sv
// Randomized bench for crc_sched with an inverting CRC engine stub and a job-level model.
module tb_crc_sched;
    localparam int unsigned N_REQ   = 2;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned DW      = 8 * N_REQ;

    logic             CLK;
    logic             RST;
    logic [N_REQ-1:0] Req;
    logic [DW-1:0]    Req_Data;
    logic [N_REQ-1:0] Grant;
    logic [N_REQ-1:0] Done;
    logic [N_REQ-1:0] Err;
    logic [7:0]       Crc_Out;
    logic             Busy;
    logic             Eng_RST;
    logic             Eng_Data;
    logic             Eng_Active;
    logic             Eng_CRC;
    logic             Eng_Valid;

    int n_checks;
    int n_errors;
    int n_jobs;
    int m_ptr;
    logic [7:0] m_crc;
    int stub_mode;  // 0 normal, 1 never valid, 2 valid drops after 3 bits

    crc_sched #(
        .N_REQ  (N_REQ),
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .Req       (Req),
        .Req_Data  (Req_Data),
        .Grant     (Grant),
        .Done      (Done),
        .Err       (Err),
        .Crc_Out   (Crc_Out),
        .Busy      (Busy),
        .Eng_RST   (Eng_RST),
        .Eng_Data  (Eng_Data),
        .Eng_Active(Eng_Active),
        .Eng_CRC   (Eng_CRC),
        .Eng_Valid (Eng_Valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Engine stub: after 8 shifted bits, returns the inverted byte LSB-first with Valid high.
    logic [7:0] st_sr;
    logic [7:0] st_out;
    int         st_nin;
    int         st_nout;
    always @(posedge CLK) begin
        if (RST || !Eng_RST) begin
            st_sr     <= '0;
            st_out    <= '0;
            st_nin    <= 0;
            st_nout   <= 0;
            Eng_Valid <= 1'b0;
            Eng_CRC   <= 1'b0;
        end else if (Eng_Active) begin
            st_sr  <= {Eng_Data, st_sr[7:1]};
            st_nin <= st_nin + 1;
            if (st_nin == 7 && stub_mode != 1) begin
                Eng_Valid <= 1'b1;
                Eng_CRC   <= ~st_sr[1];
                st_out    <= ~({Eng_Data, st_sr[7:1]} >> 1);
                st_nout   <= (stub_mode == 2) ? 2 : 7;
            end
        end else if (st_nout > 0) begin
            Eng_CRC <= st_out[0];
            st_out  <= st_out >> 1;
            st_nout <= st_nout - 1;
        end else begin
            Eng_Valid <= 1'b0;
            Eng_CRC   <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [N_REQ-1:0] g, input logic [N_REQ-1:0] d,
                                         input logic [N_REQ-1:0] e, input logic [7:0] crc,
                                         input logic busy, input logic rst, input logic dat,
                                         input logic act);
        return 32'({g, d, e, crc, busy, rst, dat, act});
    endfunction

    function automatic logic [31:0] observed();
        return pack(Grant, Done, Err, Crc_Out, Busy, Eng_RST, Eng_Data, Eng_Active);
    endfunction

    // One job from the IDLE cycle where requests are presented; checks every cycle of the
    // expected timeline (CLEAR = cycle 0). Ends at a negedge of an IDLE cycle.
    task automatic do_job(input logic [N_REQ-1:0] req, input logic [DW-1:0] data,
                          input int mode, input bit drop, input int abort_at);
        int win;
        int eend;
        int last;
        logic [7:0] b;
        logic [7:0] crc_old;
        logic [7:0] crc_new;
        logic [N_REQ-1:0] oh;
        logic [N_REQ-1:0] g;
        logic [N_REQ-1:0] d;
        logic [N_REQ-1:0] e;
        logic act;
        logic dat;
        logic [7:0] crc_exp;
        logic busy_exp;
        win = -1;
        for (int k = 0; k < N_REQ; k++) begin
            int i = (m_ptr + k) % N_REQ;
            if (win < 0 && req[i]) win = i;
        end
        oh = '0;
        oh[win] = 1'b1;
        b = data[8*win +: 8];
        m_ptr = (win + 1) % N_REQ;
        crc_old = m_crc;
        crc_new = ~b;
        eend = (mode == 1) ? 10 + TIMEOUT : 14;
        last = (mode == 0) ? 19 : eend + 1;
        stub_mode = mode;
        Req = req;
        Req_Data = data;
        for (int c = 0; c <= last; c++) begin
            @(negedge CLK);
            act = (c >= 2 && c <= 9);
            dat = act ? b[c-2] : 1'b0;
            g = (c == 0) ? oh : '0;
            d = (mode == 0 && c == 18) ? oh : '0;
            e = (mode != 0 && c == eend) ? oh : '0;
            crc_exp = (mode == 0 && c >= 18) ? crc_new : crc_old;
            busy_exp = (mode == 0) ? (c <= 18) : (c < eend);
            check_eq($sformatf("job%0d_c%0d", n_jobs, c), observed(),
                     pack(g, d, e, crc_exp, busy_exp, c != 0, dat, act));
            if (c == 0) begin
                if (drop) Req = '0;
                Req_Data = DW'($urandom);
            end
            if (c == abort_at) begin
                RST = 1'b1;
                Req = '0;
                @(negedge CLK);
                check_eq($sformatf("job%0d_abort", n_jobs), observed(),
                         pack('0, '0, '0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
                RST = 1'b0;
                m_ptr = 0;
                m_crc = 8'h00;
                n_jobs++;
                return;
            end
        end
        if (mode == 0) m_crc = crc_new;
        n_jobs++;
    endtask

    initial begin
        int mode;
        n_checks  = 0;
        n_errors  = 0;
        n_jobs    = 0;
        m_ptr     = 0;
        m_crc     = 8'h00;
        stub_mode = 0;
        RST       = 1'b1;
        Req       = '1;
        Req_Data  = '0;

        repeat (2) begin
            @(negedge CLK);
            check_eq("reset", observed(), pack('0, '0, '0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        RST = 1'b0;
        Req = '0;

        // Held requests alternate 0,1,0,1 with a 20-cycle period.
        repeat (4) do_job(2'b11, {8'hFF, 8'h00}, 0, 1'b0, -1);
        do_job(2'b01, {8'h00, 8'hA5}, 0, 1'b1, -1);
        check_eq("single_crc", 32'(Crc_Out), 32'h5A);
        do_job(2'b10, DW'($urandom), 1, 1'b1, -1);
        do_job(2'b01, DW'($urandom), 2, 1'b1, -1);
        do_job(2'b11, DW'($urandom), 0, 1'b0, 7);
        do_job(2'b10, {8'h3C, 8'h00}, 0, 1'b1, -1);
        check_eq("fresh_crc", 32'(Crc_Out), 32'hC3);

        repeat (12) begin
            mode = $urandom_range(0, 2);
            do_job(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), DW'($urandom), mode,
                   (mode != 0) ? 1'b1 : 1'($urandom_range(0, 1)), -1);
        end

        Req = '0;
        repeat (3) begin
            @(negedge CLK);
            check_eq("idle_tail", observed(), pack('0, '0, '0, m_crc, 1'b0, 1'b1, 1'b0, 1'b0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/crc_sched.md
Name: crc_sched

Overview:
- Round-robin scheduler that shares one serial CRC-8 engine (bit-serial input, bit-serial output) between N_REQ byte-oriented requesters.
- Per job: captures the winning requester's byte, clears the engine, shifts the byte in LSB-first, then collects the 8 serial CRC bits into a parallel result returned to that requester.
- Sits between requester logic and the CRC engine; the engine is instantiated beside it and wired through the Eng_* ports.

Parameters:
- N_REQ, 2, number of requesters (2..4)
- TIMEOUT, 16, max cycles in WAIT_V for Eng_Valid before abort (>=2)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- Req  in  N_REQ  request per requester; level, held until Done or Err for that requester
- Req_Data  in  8*N_REQ  byte per requester; slice i = bits [8i+7:8i]
- Grant  out  N_REQ  one-hot, 1-cycle pulse when requester's byte is captured
- Done  out  N_REQ  one-hot, 1-cycle pulse when Crc_Out is valid for that requester
- Err  out  N_REQ  one-hot, 1-cycle pulse on engine timeout or protocol fault
- Crc_Out  out  8  collected CRC byte, stable from Done until next Done
- Busy  out  1  high in every state except IDLE
- Eng_RST  out  1  engine clear, active-low (low = clear)
- Eng_Data  out  1  serial data bit to engine
- Eng_Active  out  1  engine shift enable
- Eng_CRC  in  1  serial CRC bit from engine
- Eng_Valid  in  1  engine output-valid

Behaviour:
- All outputs registered.
- Reset values: Grant=0, Done=0, Err=0, Crc_Out=8'h00, Busy=0, Eng_RST=1, Eng_Data=0, Eng_Active=0; state=IDLE; RR pointer=0.
- RST mid-job: abort immediately, no Done/Err pulse, return to reset values.
- Arbitration (IDLE only): first asserted Req found scanning from the RR pointer upward with wrap. Winner's Req_Data is captured and its index latched. Pointer = winner+1 mod N_REQ. Requests arriving during a job wait; no preemption.
- FSM, cycle numbering relative to the CLEAR cycle = 0:
  - IDLE -> CLEAR when any Req is high.
  - CLEAR (1 cycle): Grant[winner]=1, Eng_RST=0, Busy=1.
  - RECOVER (1 cycle): Eng_RST=1.
  - SHIFT (8 cycles, cycles 2..9): Eng_Active=1, Eng_Data=byte[k] for k=0..7, LSB first.
  - WAIT_V: Eng_Active=0, Eng_Data=0, counter starts at 0.
    - On an edge with Eng_Valid=1: capture Eng_CRC into Crc_Out bit 0 (shadow register) and go to COLLECT.
    - If TIMEOUT cycles elapse without Eng_Valid: Err[winner]=1 for 1 cycle, go to IDLE.
  - COLLECT (7 cycles): each edge, capture Eng_CRC into bits 1..7 in order. If Eng_Valid=0 on any edge in COLLECT: Err[winner] pulse, go to IDLE, Crc_Out unchanged.
  - DONE (1 cycle): Crc_Out updated from the shadow register, Done[winner]=1, go to IDLE.
- Crc_Out changes only on entry to DONE; an aborted job never alters it.
- Requester dropping Req after Grant: ignored, job completes and Done still pulses.
- Eng_Valid high during CLEAR/RECOVER/SHIFT: ignored.
- Back-to-back: IDLE lasts exactly 1 cycle between jobs when another Req is pending. Job period = 20 cycles with the zero-wait engine stub.
- Req_Data changes after Grant: no effect on the running job.

Test Plan:
- Engine stub: Eng_Valid high for exactly 8 cycles starting the cycle after Eng_Active falls; Eng_CRC = ~input byte, LSB first.
- Reset: drive RST=1 for 2 cycles with Req=2'b11 -> all outputs at reset values, no Grant.
- Single job: Req[0]=1, data 8'hA5 -> Grant[0] at cycle 0; Eng_Data sequence 1,0,1,0,0,1,0,1 on cycles 2..9; Done[0] at cycle 18; Crc_Out=8'h5A.
- Round-robin: Req=2'b11 held, data0=8'h00, data1=8'hFF -> Grant order 0,1,0,1; Crc_Out alternates 8'hFF, 8'h00; consecutive Grants 20 cycles apart.
- Timeout: stub never asserts Eng_Valid, TIMEOUT=16 -> Err[winner] pulse 16 cycles after WAIT_V entry; Crc_Out retains prior value; Busy=0 the next cycle.
- Valid dropout: stub drops Eng_Valid after 3 bits -> Err pulse, no Done, Crc_Out unchanged.
- Mid-job reset: assert RST at cycle 5 of SHIFT -> next cycle Eng_Active=0, Busy=0; a fresh Req then completes normally with correct Crc_Out.
